// File: rtl/cache_bus_responder.sv
// cache_bus_responder: memory-side target of the cache refill/writeback bus.
// Holds a word-addressed RAM, returns read bursts beat by beat after RD_LAT
// cycles and accepts write bursts one beat per wdata_resp pulse. The read and
// write channels run independently and may both be active in the same cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   axi_ce_i                      bus enable, gates acceptance of new bursts
//   axi_ren_i/axi_rready_i        read request (held for burst) / beat ready
//   axi_raddr_i/axi_rlen_i        read byte address / beats-1
//   rdata_o/rdata_valid_o         read beat data / valid
//   axi_wen_i/axi_wvalid_i        write request (held for burst) / unused valid
//   axi_waddr_i/axi_wlen_i        write byte address / beats-1
//   axi_wdata_i/axi_wsel_i        current write beat / byte strobes
//   axi_wlast_i                   informational, unused
//   wdata_resp_o                  write beat accepted
module cache_bus_responder #(
  parameter int unsigned DEPTH_W = 12,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned WR_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_ce_i,
  input  logic        axi_ren_i,
  input  logic        axi_rready_i,
  input  logic [31:0] axi_raddr_i,
  input  logic [7:0]  axi_rlen_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  input  logic        axi_wen_i,
  input  logic        axi_wvalid_i,
  input  logic [31:0] axi_waddr_i,
  input  logic [7:0]  axi_wlen_i,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wsel_i,
  input  logic        axi_wlast_i,
  output logic        wdata_resp_o
);

  localparam int unsigned WORDS = 1 << DEPTH_W;
  localparam int unsigned LAT_W = 8;
  localparam int unsigned LEN_W = 8;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST, R_DONE} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_BURST, W_DONE} w_state_e;

  logic [31:0] mem_q [WORDS];

  r_state_e           r_state_q, r_state_d;
  logic [DEPTH_W-1:0] r_idx_q, r_idx_d;
  logic [LEN_W-1:0]   r_len_q, r_len_d;
  logic [LEN_W-1:0]   r_cnt_q, r_cnt_d;
  logic [LAT_W-1:0]   r_lat_q, r_lat_d;
  logic               r_valid_q, r_valid_d;
  logic [31:0]        r_data_q, r_data_d;
  logic               r_launch_c;
  logic [DEPTH_W-1:0] r_launch_idx_c;

  w_state_e           w_state_q, w_state_d;
  logic [DEPTH_W-1:0] w_idx_q, w_idx_d;
  logic [LEN_W-1:0]   w_len_q, w_len_d;
  logic [LEN_W-1:0]   w_cnt_q, w_cnt_d;
  logic [LAT_W-1:0]   w_lat_q, w_lat_d;
  logic               w_resp_q, w_resp_d;
  logic               w_we_c;
  logic [DEPTH_W-1:0] w_addr_c;

  // Address bits outside the word index, wvalid and wlast carry no function here.
  logic unused_c;
  assign unused_c = ^{axi_wvalid_i, axi_wlast_i, axi_raddr_i, axi_waddr_i};

  // Read channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_lat_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_lat_q   <= r_lat_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  // Read channel next state. A "launch" registers the RAM word for the next
  // beat; reading before the same-edge write returns old data on a collision.
  always_comb begin
    r_state_d      = r_state_q;
    r_idx_d        = r_idx_q;
    r_len_d        = r_len_q;
    r_cnt_d        = r_cnt_q;
    r_lat_d        = r_lat_q;
    r_valid_d      = r_valid_q;
    r_data_d       = r_data_q;
    r_launch_c     = 1'b0;
    r_launch_idx_c = r_idx_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (axi_ce_i && axi_ren_i) begin
          r_idx_d = axi_raddr_i[DEPTH_W+1:2];
          r_len_d = axi_rlen_i;
          r_cnt_d = '0;
          r_lat_d = LAT_W'(RD_LAT - 1);
          // With a latency of one there are no wait cycles: launch on acceptance.
          if (RD_LAT <= 1) begin
            r_launch_c     = 1'b1;
            r_launch_idx_c = axi_raddr_i[DEPTH_W+1:2];
            r_valid_d      = 1'b1;
            r_state_d      = R_BURST;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (!axi_ren_i) begin
          r_state_d = R_IDLE;
        end else begin
          r_lat_d = r_lat_q - LAT_W'(1);
          // Launch on the edge where the counter reaches zero.
          if (r_lat_q == LAT_W'(1)) begin
            r_launch_c = 1'b1;
            r_valid_d  = 1'b1;
            r_state_d  = R_BURST;
          end
        end
      end
      R_BURST: begin
        if (!axi_ren_i) begin
          r_valid_d = 1'b0;
          r_state_d = R_IDLE;
        end else if (r_valid_q && axi_rready_i) begin
          if (r_cnt_q == r_len_q) begin
            r_valid_d = 1'b0;
            r_state_d = R_DONE;
          end else begin
            r_cnt_d        = r_cnt_q + LEN_W'(1);
            r_launch_c     = 1'b1;
            r_launch_idx_c = r_idx_q + DEPTH_W'(r_cnt_d);
          end
        end
      end
      R_DONE: begin
        if (!axi_ren_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_launch_c) r_data_d = mem_q[r_launch_idx_c];
  end

  assign rdata_o       = r_data_q;
  assign rdata_valid_o = r_valid_q & axi_ren_i;

  // Write channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_lat_q   <= '0;
      w_resp_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_lat_q   <= w_lat_d;
      w_resp_q  <= w_resp_d;
    end
  end

  // Write channel next state: resp alternates high/low, one beat per pulse.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_lat_d   = w_lat_q;
    w_resp_d  = w_resp_q;
    w_we_c    = 1'b0;
    w_addr_c  = w_idx_q + DEPTH_W'(w_cnt_q);
    unique case (w_state_q)
      W_IDLE: begin
        if (axi_ce_i && axi_wen_i) begin
          w_idx_d = axi_waddr_i[DEPTH_W+1:2];
          w_len_d = axi_wlen_i;
          w_cnt_d = '0;
          w_lat_d = LAT_W'(WR_LAT - 1);
          if (WR_LAT <= 1) begin
            w_resp_d  = 1'b1;
            w_state_d = W_BURST;
          end else begin
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (!axi_wen_i) begin
          w_state_d = W_IDLE;
        end else begin
          w_lat_d = w_lat_q - LAT_W'(1);
          if (w_lat_q == LAT_W'(1)) begin
            w_resp_d  = 1'b1;
            w_state_d = W_BURST;
          end
        end
      end
      W_BURST: begin
        if (!axi_wen_i) begin
          w_resp_d  = 1'b0;
          w_state_d = W_IDLE;
        end else if (w_resp_q) begin
          w_we_c   = 1'b1;
          w_resp_d = 1'b0;
          if (w_cnt_q == w_len_q) w_state_d = W_DONE;
          else                    w_cnt_d   = w_cnt_q + LEN_W'(1);
        end else begin
          w_resp_d = 1'b1;
        end
      end
      W_DONE: begin
        if (!axi_wen_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign wdata_resp_o = w_resp_q & axi_wen_i;

  // RAM write port with per-byte strobes; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_wsel_i[b]) mem_q[w_addr_c][8*b +: 8] <= axi_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cache_bus_responder.sv
// Directed bench for cache_bus_responder: per-cycle vector tables for the
// read, write and stall timing, plus bus-level tasks and hand sequences for
// strobes, address wrap, read/write collision and reset mid-burst.
module tb_cache_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        axi_ce_i, axi_ren_i, axi_rready_i;
  logic [31:0] axi_raddr_i;
  logic [7:0]  axi_rlen_i;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        axi_wen_i, axi_wvalid_i;
  logic [31:0] axi_waddr_i;
  logic [7:0]  axi_wlen_i;
  logic [31:0] axi_wdata_i;
  logic [3:0]  axi_wsel_i;
  logic        axi_wlast_i;
  logic        wdata_resp_o;

  always #5 clk = ~clk;

  cache_bus_responder #(.DEPTH_W(12), .RD_LAT(2), .WR_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .axi_ce_i(axi_ce_i), .axi_ren_i(axi_ren_i), .axi_rready_i(axi_rready_i),
    .axi_raddr_i(axi_raddr_i), .axi_rlen_i(axi_rlen_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .axi_wen_i(axi_wen_i), .axi_wvalid_i(axi_wvalid_i),
    .axi_waddr_i(axi_waddr_i), .axi_wlen_i(axi_wlen_i),
    .axi_wdata_i(axi_wdata_i), .axi_wsel_i(axi_wsel_i),
    .axi_wlast_i(axi_wlast_i), .wdata_resp_o(wdata_resp_o)
  );

  typedef struct {
    logic        ce;
    logic        ren;
    logic        rready;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic        wen;
    logic [31:0] waddr;
    logic [7:0]  wlen;
    logic [31:0] wdata;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ce, input logic ren, input logic rready,
                              input logic [31:0] raddr, input logic [7:0] rlen,
                              input logic wen, input logic [31:0] waddr,
                              input logic [7:0] wlen, input logic [31:0] wdata,
                              input logic erv, input logic [31:0] erd, input logic ewr);
    vec_t v;
    v.ce = ce; v.ren = ren; v.rready = rready; v.raddr = raddr; v.rlen = rlen;
    v.wen = wen; v.waddr = waddr; v.wlen = wlen; v.wdata = wdata;
    v.exp_rv = erv; v.exp_rd = erd; v.exp_wr = ewr;
    return v;
  endfunction

  // Read-only row.
  function automatic vec_t rdv(input logic ce, input logic ren, input logic rready,
                               input logic [31:0] raddr, input logic [7:0] rlen,
                               input logic erv, input logic [31:0] erd);
    return mk(ce, ren, rready, raddr, rlen, 1'b0, 32'h0, 8'h0, 32'h0, erv, erd, 1'b0);
  endfunction

  // Write-only row.
  function automatic vec_t wrv(input logic wen, input logic [31:0] waddr,
                               input logic [7:0] wlen, input logic [31:0] wdata,
                               input logic ewr);
    return mk(1'b1, 1'b0, 1'b1, 32'h0, 8'h0, wen, waddr, wlen, wdata, 1'b0, 32'h0, ewr);
  endfunction

  // One row per cycle: drive after the rising edge, compare at the falling edge.
  task automatic run_vecs(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk); #1;
      axi_ce_i     = tbl[i].ce;
      axi_ren_i    = tbl[i].ren;
      axi_rready_i = tbl[i].rready;
      axi_raddr_i  = tbl[i].raddr;
      axi_rlen_i   = tbl[i].rlen;
      axi_wen_i    = tbl[i].wen;
      axi_wvalid_i = tbl[i].wen;
      axi_waddr_i  = tbl[i].waddr;
      axi_wlen_i   = tbl[i].wlen;
      axi_wdata_i  = tbl[i].wdata;
      axi_wsel_i   = 4'hF;
      @(negedge clk);
      check($sformatf("%s[%0d].rvalid", tag, i - lo), 32'(rdata_valid_o), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv)
        check($sformatf("%s[%0d].rdata", tag, i - lo), rdata_o, tbl[i].exp_rd);
      check($sformatf("%s[%0d].wresp", tag, i - lo), 32'(wdata_resp_o), 32'(tbl[i].exp_wr));
    end
  endtask

  // Write burst of wbuf[0..len]; wdata follows the observed resp pulses.
  task automatic bus_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] sel);
    int k = 0;
    int cyc = 0;
    @(posedge clk); #1;
    axi_ce_i = 1'b1; axi_wen_i = 1'b1; axi_wvalid_i = 1'b1;
    axi_waddr_i = addr; axi_wlen_i = len; axi_wsel_i = sel; axi_wdata_i = wbuf[0];
    forever begin
      @(negedge clk);
      if (wdata_resp_o) k++;
      cyc++;
      if (k == int'(len) + 1 || cyc > 64) break;
      @(posedge clk); #1;
      axi_wdata_i = wbuf[k];
    end
    check($sformatf("wr@%h.beats", addr), 32'(k), 32'(int'(len) + 1));
    @(posedge clk); #1;
    axi_wen_i = 1'b0; axi_wvalid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Read burst into rbuf[0..len] with rready held high.
  task automatic bus_read(input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    int cyc = 0;
    @(posedge clk); #1;
    axi_ce_i = 1'b1; axi_ren_i = 1'b1; axi_rready_i = 1'b1;
    axi_raddr_i = addr; axi_rlen_i = len;
    forever begin
      @(negedge clk);
      if (rdata_valid_o) begin
        rbuf[n] = rdata_o;
        n++;
      end
      cyc++;
      if (n == int'(len) + 1 || cyc > 64) break;
      @(posedge clk); #1;
    end
    check($sformatf("rd@%h.beats", addr), 32'(n), 32'(int'(len) + 1));
    @(posedge clk); #1;
    axi_ren_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1_lo, t1_hi, t2_lo, t2_hi, t4_lo, t4_hi;

    // Read of 0x100 (word 0x40) with len=7, request dropped after beat 3,
    // then a new one-beat read at cycle 7 proving the FSM is idle again.
    t1_lo = tbl.size();
    tbl.push_back(rdv(1, 1, 1, 32'h100, 8'd7, 0, 32'h0));
    tbl.push_back(rdv(1, 1, 1, 32'h100, 8'd7, 0, 32'h0));
    tbl.push_back(rdv(1, 1, 1, 32'h100, 8'd7, 1, 32'h1000));
    tbl.push_back(rdv(1, 1, 1, 32'h100, 8'd7, 1, 32'h1001));
    tbl.push_back(rdv(1, 1, 1, 32'h100, 8'd7, 1, 32'h1002));
    tbl.push_back(rdv(1, 1, 1, 32'h100, 8'd7, 1, 32'h1003));
    tbl.push_back(rdv(1, 0, 1, 32'h100, 8'd7, 0, 32'h0));
    tbl.push_back(rdv(1, 1, 1, 32'h104, 8'd0, 0, 32'h0));
    tbl.push_back(rdv(1, 1, 1, 32'h104, 8'd0, 0, 32'h0));
    tbl.push_back(rdv(1, 1, 1, 32'h104, 8'd0, 1, 32'h1001));
    tbl.push_back(rdv(1, 1, 1, 32'h104, 8'd0, 0, 32'h0));
    tbl.push_back(rdv(1, 0, 1, 32'h0,   8'd0, 0, 32'h0));
    t1_hi = tbl.size();

    // Write 0x200 len=3: resp at cycles 1,3,5,7, data 0xA0+k per beat.
    t2_lo = tbl.size();
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA0, 0));
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA0, 1));
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA1, 0));
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA1, 1));
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA2, 0));
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA2, 1));
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA3, 0));
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA3, 1));
    tbl.push_back(wrv(1, 32'h200, 8'd3, 32'hA3, 0));
    tbl.push_back(wrv(0, 32'h0,   8'd0, 32'h0,  0));
    t2_hi = tbl.size();

    // Stall: rready 1,0,0,1 with ce low mid-burst, then ce low blocks acceptance.
    t4_lo = tbl.size();
    tbl.push_back(rdv(1, 1, 1, 32'h100, 8'd3, 0, 32'h0));
    tbl.push_back(rdv(1, 1, 1, 32'h100, 8'd3, 0, 32'h0));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 1, 32'h1000));
    tbl.push_back(rdv(0, 1, 0, 32'h100, 8'd3, 1, 32'h1001));
    tbl.push_back(rdv(0, 1, 0, 32'h100, 8'd3, 1, 32'h1001));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 1, 32'h1001));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 1, 32'h1002));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 1, 32'h1003));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 0, 32'h0));
    tbl.push_back(rdv(0, 0, 1, 32'h100, 8'd3, 0, 32'h0));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 0, 32'h0));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 0, 32'h0));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 0, 32'h0));
    tbl.push_back(rdv(0, 1, 1, 32'h100, 8'd3, 0, 32'h0));
    tbl.push_back(rdv(1, 0, 1, 32'h0,   8'd0, 0, 32'h0));
    t4_hi = tbl.size();

    rst = 1'b0;
    axi_ce_i = 1'b0; axi_ren_i = 1'b0; axi_rready_i = 1'b0;
    axi_raddr_i = '0; axi_rlen_i = '0;
    axi_wen_i = 1'b0; axi_wvalid_i = 1'b0; axi_waddr_i = '0; axi_wlen_i = '0;
    axi_wdata_i = '0; axi_wsel_i = '0; axi_wlast_i = 1'b0;

    #12;
    check("reset.rdata",  rdata_o,                32'h0);
    check("reset.rvalid", 32'(rdata_valid_o),     32'h0);
    check("reset.wresp",  32'(wdata_resp_o),      32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Preload words 0x40..0x47 with 0x1000+i.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
    bus_write(32'h100, 8'd7, 4'hF);

    run_vecs("rd_drop", t1_lo, t1_hi);
    run_vecs("wr_burst", t2_lo, t2_hi);
    @(posedge clk); #1;
    bus_read(32'h200, 8'd3);
    for (int i = 0; i < 4; i++)
      check($sformatf("wr_readback%0d", i), rbuf[i], 32'hA0 + 32'(i));

    run_vecs("rd_stall", t4_lo, t4_hi);

    // Byte strobes 0101 over 0x12345678.
    wbuf[0] = 32'h12345678;
    bus_write(32'h300, 8'd0, 4'hF);
    wbuf[0] = 32'hFFFFFFFF;
    bus_write(32'h300, 8'd0, 4'b0101);
    bus_read(32'h300, 8'd0);
    check("wsel_merge", rbuf[0], 32'h12FF56FF);

    // Wrap from word index 4094; upper address bits are ignored on the read.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
    bus_write(32'h3FF8, 8'd3, 4'hF);
    bus_read(32'hFFFF_FFF8, 8'd3);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_rd%0d", i), rbuf[i], 32'hB0 + 32'(i));
    bus_read(32'h0, 8'd1);
    check("wrap_idx0", rbuf[0], 32'hB2);
    check("wrap_idx1", rbuf[1], 32'hB3);

    // Concurrent read and write of the line at 0x400, then reset in R_BURST.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + 32'(i);
    bus_write(32'h400, 8'd3, 4'hF);
    @(posedge clk); #1;
    axi_ce_i = 1'b1;
    axi_ren_i = 1'b1; axi_rready_i = 1'b1; axi_raddr_i = 32'h400; axi_rlen_i = 8'd3;
    axi_wen_i = 1'b1; axi_wvalid_i = 1'b1; axi_waddr_i = 32'h400; axi_wlen_i = 8'd3;
    axi_wsel_i = 4'hF; axi_wdata_i = 32'hD0;
    @(negedge clk);
    check("coll.c0.rvalid", 32'(rdata_valid_o), 32'h0);
    check("coll.c0.wresp",  32'(wdata_resp_o),  32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("coll.c1.rvalid", 32'(rdata_valid_o), 32'h0);
    check("coll.c1.wresp",  32'(wdata_resp_o),  32'h1);
    @(posedge clk); #1;
    axi_wdata_i = 32'hD1;
    @(negedge clk);
    check("coll.c2.rvalid", 32'(rdata_valid_o), 32'h1);
    check("coll.c2.old",    rdata_o,            32'hC0);
    check("coll.c2.wresp",  32'(wdata_resp_o),  32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("coll.c3.rdata",  rdata_o,            32'hC1);
    check("coll.c3.wresp",  32'(wdata_resp_o),  32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid.rdata",  rdata_o,            32'h0);
    check("rst_mid.rvalid", 32'(rdata_valid_o), 32'h0);
    check("rst_mid.wresp",  32'(wdata_resp_o),  32'h0);
    @(posedge clk); #1;
    check("rst_hold.rvalid", 32'(rdata_valid_o), 32'h0);
    check("rst_hold.wresp",  32'(wdata_resp_o),  32'h0);
    axi_ren_i = 1'b0; axi_wen_i = 1'b0; axi_wvalid_i = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    // Beat 0 landed before reset; beat 1 was cut off by the reset.
    bus_read(32'h400, 8'd3);
    check("post_rst0", rbuf[0], 32'hD0);
    check("post_rst1", rbuf[1], 32'hC1);
    check("post_rst2", rbuf[2], 32'hC2);
    check("post_rst3", rbuf[3], 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_bus_responder.md
# cache_bus_responder

Memory-side responder for the cache refill/writeback bus driven by the cache-to-bus arbiter, i.e. the target end of the `axi_ren/axi_raddr/rdata_valid` and `axi_wen/axi_waddr/wdata_resp` handshakes. It holds a word-addressed RAM and returns read bursts beat by beat after a configurable latency. It accepts write bursts one beat per `wdata_resp` pulse. Read and write channels are independent and can be active in the same cycle. It serves as the bench/FPGA memory model behind the icache and dcache.

## Interface
- `DEPTH_W`, 12: log2 of RAM depth in 32-bit words.
- `RD_LAT`, 2: cycles from read acceptance to first `rdata_valid` (≥1).
- `WR_LAT`, 1: cycles from write acceptance to first `wdata_resp` (≥1).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `axi_ce_i`  in  1  bus enable; low: no new request accepted.
- `axi_ren_i`  in  1  read request, held high for the whole burst.
- `axi_rready_i`  in  1  initiator can take a beat.
- `axi_raddr_i`  in  32  read byte address, sampled at acceptance.
- `axi_rlen_i`  in  8  beats-1, sampled at acceptance.
- `rdata_o`  out  32  read beat data.
- `rdata_valid_o`  out  1  read beat valid.
- `axi_wen_i`  in  1  write request, held high for the whole burst.
- `axi_wvalid_i`  in  1  write data valid; ignored (the initiator ties it to `axi_wen_i`).
- `axi_waddr_i`  in  32  write byte address, sampled at acceptance.
- `axi_wlen_i`  in  8  beats-1, sampled at acceptance.
- `axi_wdata_i`  in  32  current write beat, driven combinationally by the initiator.
- `axi_wsel_i`  in  4  byte strobes; applied per beat.
- `axi_wlast_i`  in  1  informational; ignored by this block.
- `wdata_resp_o`  out  1  write beat accepted.

## Operation
- Word index: `addr[DEPTH_W+1:2]`. Beat k uses index+k, wrapping modulo 2^DEPTH_W. Bits above DEPTH_W+1 are ignored.
- Read FSM states: R_IDLE, R_WAIT, R_BURST, R_DONE.
  - R_IDLE: when `axi_ce_i & axi_ren_i`, latch index, latch len=rlen, and load the latency counter with RD_LAT-1. Go to R_WAIT.
  - R_WAIT: count down. At 0, launch beat 0 and go to R_BURST.
  - R_BURST: a registered beat is presented. When `rdata_valid_o & axi_rready_i`, the beat is consumed and the next beat is launched in the following cycle. If `axi_rready_i` is low, `rdata_o` and the internal valid hold.
  - After the beat with count==len is consumed, go to R_DONE.
  - R_DONE: wait for `axi_ren_i`=0, then go to R_IDLE. This prevents re-triggering on a held request.
- Write FSM states: W_IDLE, W_WAIT, W_BURST, W_DONE.
  - W_IDLE: when `axi_ce_i & axi_wen_i`, latch index and len=wlen, and load the counter with WR_LAT-1. Go to W_WAIT.
  - W_WAIT: count down. At 0, go to W_BURST.
  - W_BURST: `wdata_resp_o` pulses high one cycle per beat, with one idle cycle between pulses. In each cycle where `wdata_resp_o & axi_wen_i` is high, write `axi_wdata_i` to RAM[index+count] under `axi_wsel_i` at the closing edge, then increment count.
  - After beat count==len is written, go to W_DONE.
  - W_DONE: wait for `axi_wen_i`=0, then go to W_IDLE.
- Output gating: `rdata_valid_o` = internal valid & `axi_ren_i`. `wdata_resp_o` = internal resp & `axi_wen_i`. This means a beat is never signalled after the initiator drops its request.
- Early termination: `axi_ren_i` low in R_WAIT or R_BURST returns the FSM to R_IDLE next cycle, and the remaining beats are discarded. Write termination works the same way. This is the normal case for 4-beat line fills issued with len=7.
- Collision: a read and a write to the same word in the same cycle return the old data.
- `axi_ce_i` low during a burst does not abort it; only acceptance is gated.

## Timing
- Reset: `rdata_o`=0, `rdata_valid_o`=0, `wdata_resp_o`=0, both FSMs idle, counters 0. RAM contents are not reset.
- Reset asserted mid-burst: outputs go to 0 immediately and asynchronously. No RAM write occurs after reset asserts.
- Read: request high at cycle 0 gives beat 0 valid at cycle RD_LAT. Beats are back-to-back while `axi_rready_i`=1.
- Write: request high at cycle 0 gives the first `wdata_resp_o` at cycle WR_LAT. Pulses then follow every 2 cycles.
- Idle between bursts: at least 1 cycle, set by the R_DONE/W_DONE request-drop requirement.

## Test plan
- Preload RAM[0x40..0x47]=0x1000+i. Issue a read at 0x100, rlen=7, rready=1, and drop ren after the 4th beat. Required: valids at cycles 2,3,4,5 with data 0x1000..0x1003, no valid at cycle 6, and the FSM in R_IDLE by cycle 7.
- Write at 0x200, wlen=3, data 0xA0+k, wsel=1111. Required: resp at cycles 1,3,5,7; then a read of 0x200 returns 0xA0..0xA3.
- Write one beat with wsel=0101 and data 0xFFFFFFFF over 0x12345678. Required: RAM word reads back 0x12FF56FF.
- Read with rready toggling 1,0,0,1 during the burst. Required: data held through the stall and no beat skipped or duplicated.
- Read at word index 2^DEPTH_W-2 with 4 beats. Required: indices wrap to 0 and 1.
- Concurrent read and write to the same line, then assert reset in R_BURST. Required: old data is returned on the collided beat, outputs are 0 in the reset cycle, and the next request after reset release is accepted normally.
